// File: rtl/lcd_scan_if.sv
// Display-RAM read port shared between the LCD scanner and the CPU core.
// The scanner is the master. It raises ram_req with ram_addr, and the RAM
// side answers with ram_gnt. Data appears on ram_dout one clk after a
// granted request.
interface lcd_scan_if #(
    parameter int RAM_AW = 7
);
    logic              ram_req;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_gnt;
    logic [3:0]        ram_dout;

    modport master (
        output ram_req,
        output ram_addr,
        input  ram_gnt,
        input  ram_dout
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        output ram_gnt,
        output ram_dout
    );
endinterface

// File: rtl/lcd_scan.sv
// LCD multiplex scanner. Each common slot reads BANKS*SEGS nibbles of
// display RAM and keeps bit [cidx] of each nibble in a shadow register.
// It then updates the segment outputs, the one-hot common strobe and the
// Bs backplane together, so a slot that has only been partly read never
// reaches the pins.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for the slot tick
// READ  | requesting RAM reads, index advances on each grant
// DRAIN | last granted read returns its data this clk
// LATCH | shadow -> seg; com/bs/frame_start update; next common
module lcd_scan #(
    parameter int                COMMONS   = 4,
    parameter int                SEGS      = 16,
    parameter int                BANKS     = 2,
    parameter int                RAM_AW    = 7,
    parameter logic [RAM_AW-1:0] DISP_BASE = 7'h60,
    parameter int                TICK_DIV  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  bp,
    input  logic                  bc,
    input  logic [3:0]            l_reg,
    input  logic [3:0]            y_reg,
    lcd_scan_if.master            bus,
    output logic [BANKS*SEGS-1:0] seg,
    output logic [COMMONS-1:0]    com,
    output logic                  bs,
    output logic                  frame_start,
    output logic                  overrun
);

    localparam int N  = BANKS * SEGS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [1:0]    CIDX_LAST = 2'(COMMONS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [TW-1:0]     tick_cnt;
    logic              tick;

    logic              req;
    logic [RAM_AW-1:0] addr;
    logic [KW-1:0]     k;
    logic              grant;
    logic              last_grant;

    logic              cap_vld;
    logic [KW-1:0]     cap_idx;
    logic [N-1:0]      shadow;

    logic [1:0]        cidx;
    logic              disp_en;
    logic [3:0]        bs_pat;

    assign tick       = ce && (tick_cnt == TICK_LAST);
    assign grant      = req && bus.ram_gnt;
    assign last_grant = grant && (k == K_LAST);
    assign disp_en    = bp && !bc;
    assign bs_pat     = l_reg & ~y_reg;

    assign bus.ram_req  = req;
    assign bus.ram_addr = addr;

    // Slot timer: counts ce pulses and wraps after TICK_DIV of them.
    // The wrap keeps going even while a scan overruns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (ce) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode. A tick outside IDLE is dropped here; it is
    // flagged as an overrun in the status register.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = READ;
            READ:    if (last_grant) state_nxt = DRAIN;
            DRAIN:   state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read port. The address is held while the grant is low and parks at
    // DISP_BASE between scans.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req  <= 1'b0;
            addr <= DISP_BASE;
            k    <= '0;
        end else if ((state == IDLE) && tick) begin
            req  <= 1'b1;
            addr <= DISP_BASE;
            k    <= '0;
        end else if (last_grant) begin
            req  <= 1'b0;
            addr <= DISP_BASE;
            k    <= '0;
        end else if (grant) begin
            addr <= addr + RAM_AW'(1);
            k    <= k + KW'(1);
        end
    end

    // Capture the returning nibble one clk after its grant. Only bit [cidx]
    // of the nibble is needed for this common.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
            shadow  <= '0;
        end else begin
            cap_vld <= grant;
            cap_idx <= k;
            if (cap_vld) begin
                shadow[cap_idx] <= bus.ram_dout[cidx];
            end
        end
    end

    // Output latch. bp/bc/l_reg/y_reg are looked at only here, so register
    // writes made mid-scan take effect at a slot boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg         <= '0;
            com         <= '0;
            bs          <= 1'b0;
            frame_start <= 1'b0;
            cidx        <= 2'd0;
        end else begin
            frame_start <= 1'b0;
            if (state == LATCH) begin
                seg         <= disp_en ? shadow : '0;
                com         <= COMMONS'(1) << cidx;
                bs          <= disp_en && bs_pat[cidx];
                frame_start <= (cidx == 2'd0);
                cidx        <= (cidx == CIDX_LAST) ? 2'd0 : cidx + 2'd1;
            end
        end
    end

    // Sticky overrun: the slot tick came before the previous scan finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_scan.sv
// Directed bench for lcd_scan. The main instance uses the default geometry
// with a short slot (TICK_DIV=40, with ce on every other clk, gives 80 clks
// per slot). A second instance runs the COMMONS=3 / 1x8 / base 0x7C sweep.
module tb_lcd_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        bp;
    logic        bc;
    logic [3:0]  l_reg;
    logic [3:0]  y_reg;
    logic [31:0] seg;
    logic [3:0]  com;
    logic        bs;
    logic        frame_start;
    logic        overrun;

    logic [7:0]  seg2;
    logic [2:0]  com2;
    logic        bs2;
    logic        fs2;
    logic        ovr2;

    lcd_scan_if #(.RAM_AW(7)) bus ();
    lcd_scan_if #(.RAM_AW(7)) bus2 ();

    lcd_scan #(
        .COMMONS(4), .SEGS(16), .BANKS(2), .RAM_AW(7),
        .DISP_BASE(7'h60), .TICK_DIV(40)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .bp(bp), .bc(bc),
        .l_reg(l_reg), .y_reg(y_reg), .bus(bus),
        .seg(seg), .com(com), .bs(bs),
        .frame_start(frame_start), .overrun(overrun)
    );

    lcd_scan #(
        .COMMONS(3), .SEGS(8), .BANKS(1), .RAM_AW(7),
        .DISP_BASE(7'h7C), .TICK_DIV(12)
    ) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .bp(1'b1), .bc(1'b0),
        .l_reg(4'b0000), .y_reg(4'b0000), .bus(bus2),
        .seg(seg2), .com(com2), .bs(bs2),
        .frame_start(fs2), .overrun(ovr2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM model and grant generator. Inputs change on the falling edge.
    logic [3:0] mem [0:127];
    int         gnt_mode  = 0;     // 0: always grant, 1: toggle, 2: hold off
    logic       g         = 1'b1;
    logic       pend_vld  = 1'b0;
    logic [6:0] pend_addr = 7'h0;
    logic       prev_hold = 1'b0;
    logic [6:0] prev_addr = 7'h0;
    int         gidx      = 0;
    int         hold_bad  = 0;
    int         seq_bad   = 0;
    logic       pend2_vld = 1'b0;
    logic [6:0] pend2_addr = 7'h0;
    logic [6:0] q2 [$];

    always @(negedge clk) begin
        ce = ~ce;
        bus.ram_dout = pend_vld ? mem[pend_addr] : 4'h0;
        if (prev_hold && bus.ram_req && (bus.ram_addr != prev_addr)) hold_bad++;
        case (gnt_mode)
            0:       g = 1'b1;
            1:       g = ~g;
            default: g = 1'b0;
        endcase
        bus.ram_gnt = g;
        if (!bus.ram_req) gidx = 0;
        pend_vld  = bus.ram_req && g;
        pend_addr = bus.ram_addr;
        if (pend_vld) begin
            if (bus.ram_addr != 7'(7'h60 + 7'(gidx))) seq_bad++;
            gidx++;
        end
        prev_hold = bus.ram_req && !g;
        prev_addr = bus.ram_addr;

        bus2.ram_dout = pend2_vld ? pend2_addr[3:0] : 4'h0;
        bus2.ram_gnt  = 1'b1;
        pend2_vld  = bus2.ram_req;
        pend2_addr = bus2.ram_addr;
        if (pend2_vld && (q2.size() < 8)) q2.push_back(bus2.ram_addr);
    end

    // One slot on the main instance: waits for ram_req, then for the com
    // update. It returns the req-fall and latch offsets from the tick edge.
    task automatic scan_slot(output int t_fall, output int t_latch);
        logic [3:0] com0;
        int n;
        int t0;
        com0 = com;
        n = 0;
        while (!bus.ram_req && n < 400) begin step(); n++; end
        t0 = cyc;
        while (bus.ram_req && n < 400) begin step(); n++; end
        t_fall = cyc - t0;
        while ((com == com0) && n < 400) begin step(); n++; end
        t_latch = cyc - t0;
        if (n >= 400) check_val("slot_timeout", 64'd1, 64'd0);
    endtask

    logic [31:0] s_exp  [3];
    logic [3:0]  c_exp  [3];
    logic        b_exp  [3];
    logic [7:0]  s2_exp [4];
    logic [2:0]  c2_exp [4];
    logic        f2_exp [4];
    logic [6:0]  a2_exp [8];
    logic        done2 = 1'b0;

    // Parameter sweep instance: address wrap and 3-common rotation.
    initial begin
        logic [2:0] c0;
        int n;
        s2_exp = '{8'hAA, 8'hCC, 8'h0F, 8'hAA};
        c2_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        f2_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
        a2_exp = '{7'h7C, 7'h7D, 7'h7E, 7'h7F, 7'h00, 7'h01, 7'h02, 7'h03};
        wait (rst === 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            c0 = com2;
            n = 0;
            while ((com2 == c0) && n < 200) begin step(); n++; end
            if (n >= 200) check_val("p_timeout", 64'd1, 64'd0);
            check_val("p_seg", 64'(seg2), 64'(s2_exp[i]));
            check_val("p_com", 64'(com2), 64'(c2_exp[i]));
            check_val("p_fs", 64'(fs2), 64'(f2_exp[i]));
        end
        check_val("p_bs", 64'(bs2), 64'd0);
        check_val("p_ovr", 64'(ovr2), 64'd0);
        check_val("p_nreads", 64'(q2.size()), 64'd8);
        for (int i = 0; i < 8 && i < q2.size(); i++)
            check_val("p_addr", 64'(q2[i]), 64'(a2_exp[i]));
        done2 = 1'b1;
    end

    initial begin
        int tf;
        int tl;
        int l0;
        int n;
        logic [3:0] c0;
        rst = 1'b0; ce = 1'b0; bp = 1'b1; bc = 1'b0;
        l_reg = 4'b1111; y_reg = 4'b0100; gnt_mode = 0;
        for (int i = 0; i < 128; i++) mem[i] = 4'b0101;
        s_exp = '{32'h0, 32'hFFFF_FFFF, 32'h0};
        c_exp = '{4'b0010, 4'b0100, 4'b1000};
        b_exp = '{1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_seg", 64'(seg), 64'd0);
        check_val("rst_com", 64'(com), 64'd0);
        check_val("rst_bs", 64'(bs), 64'd0);
        check_val("rst_fs", 64'(frame_start), 64'd0);
        check_val("rst_ovr", 64'(overrun), 64'd0);
        check_val("rst_req", 64'(bus.ram_req), 64'd0);
        check_val("rst_addr", 64'(bus.ram_addr), 64'h60);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Slot 0 of frame 1
        scan_slot(tf, tl);
        l0 = cyc;
        check_val("s0_fall", 64'(tf), 64'd32);
        check_val("s0_latch", 64'(tl), 64'd34);
        check_val("s0_seg", 64'(seg), 64'hFFFF_FFFF);
        check_val("s0_com", 64'(com), 64'b0001);
        check_val("s0_fs", 64'(frame_start), 64'd1);
        check_val("s0_bs", 64'(bs), 64'd1);
        check_val("s0_seq", 64'(seq_bad), 64'd0);
        step();
        check_val("s0_fs_end", 64'(frame_start), 64'd0);

        for (int i = 0; i < 3; i++) begin
            scan_slot(tf, tl);
            check_val("s_seg", 64'(seg), 64'(s_exp[i]));
            check_val("s_com", 64'(com), 64'(c_exp[i]));
            check_val("s_bs", 64'(bs), 64'(b_exp[i]));
            check_val("s_fs", 64'(frame_start), 64'd0);
        end

        // New data; display disabled for this slot
        for (int i = 0; i < 32; i++) mem[7'h60 + i] = 4'(i);
        bp = 1'b0;
        scan_slot(tf, tl);
        check_val("frame_period", 64'(cyc - l0), 64'd320);
        check_val("bp0_fs", 64'(frame_start), 64'd1);
        check_val("bp0_com", 64'(com), 64'b0001);
        check_val("bp0_seg", 64'(seg), 64'd0);
        check_val("bp0_bs", 64'(bs), 64'd0);

        bp = 1'b1; bc = 1'b1;
        scan_slot(tf, tl);
        check_val("bc1_com", 64'(com), 64'b0010);
        check_val("bc1_seg", 64'(seg), 64'd0);
        check_val("bc1_bs", 64'(bs), 64'd0);

        // Grant toggling each clk
        bc = 1'b0; gnt_mode = 1;
        scan_slot(tf, tl);
        check_val("tog_latch", 64'((tl >= 65) && (tl <= 66)), 64'd1);
        check_val("tog_seg", 64'(seg), 64'hF0F0_F0F0);
        check_val("tog_com", 64'(com), 64'b0100);
        check_val("tog_bs", 64'(bs), 64'd0);
        check_val("tog_hold", 64'(hold_bad), 64'd0);
        check_val("tog_seq", 64'(seq_bad), 64'd0);

        // Grant withheld past the next tick
        gnt_mode = 2;
        c0 = com;
        n = 0;
        while (!bus.ram_req && n < 400) begin step(); n++; end
        check_val("ovr_req_rise", 64'(bus.ram_req), 64'd1);
        repeat (100) step();
        check_val("ovr_set", 64'(overrun), 64'd1);
        check_val("ovr_req_held", 64'(bus.ram_req), 64'd1);
        check_val("ovr_addr_held", 64'(bus.ram_addr), 64'h60);
        gnt_mode = 0;
        n = 0;
        while ((com == c0) && n < 200) begin step(); n++; end
        check_val("ovr_seg", 64'(seg), 64'hFF00_FF00);
        check_val("ovr_com", 64'(com), 64'b1000);
        check_val("ovr_bs", 64'(bs), 64'd1);
        check_val("ovr_sticky", 64'(overrun), 64'd1);

        // Asynchronous reset in the middle of the next scan
        n = 0;
        while (!bus.ram_req && n < 400) begin step(); n++; end
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_seg", 64'(seg), 64'd0);
        check_val("arst_com", 64'(com), 64'd0);
        check_val("arst_ovr", 64'(overrun), 64'd0);
        check_val("arst_req", 64'(bus.ram_req), 64'd0);
        check_val("arst_addr", 64'(bus.ram_addr), 64'h60);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();
        scan_slot(tf, tl);
        check_val("fresh_latch", 64'(tl), 64'd34);
        check_val("fresh_com", 64'(com), 64'b0001);
        check_val("fresh_seg", 64'(seg), 64'hAAAA_AAAA);
        check_val("fresh_fs", 64'(frame_start), 64'd1);
        check_val("fresh_bs", 64'(bs), 64'd1);

        n = 0;
        while (!done2 && n < 2000) begin step(); n++; end
        check_val("sweep_done", 64'(done2), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_scan.md
# lcd_scan

Parametrised LCD multiplex driver for the SM5xx handheld core family. It scans display RAM over a shared read port with a request/grant handshake and drives segment banks, one-hot common strobes and the Bs backplane output. COMMONS, bank count, bank width and display base address are parameters. The block replaces the fixed 4-common, 2×16-segment scanner inside the CPU and adds overrun detection and a frame marker.

## Interface
Parameters:
- COMMONS, 4: number of common lines (1..4); also the RAM bit index range.
- SEGS, 16: segments per bank.
- BANKS, 2: number of segment banks; total reads per slot N = BANKS*SEGS.
- RAM_AW, 7: display RAM address width.
- DISP_BASE, 7'h60: RAM address of bank 0, segment 0.
- TICK_DIV, 512: ce pulses per common slot (≥ N+4 clocks worth; ≥2).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-low.
- ce, input, 1: 32.768 kHz clock-enable pulse, one clk wide.
- bp, input, 1: display enable (ATBP latch); 0 blanks segments.
- bc, input, 1: bleeder current; 1 blanks segments.
- l_reg, input, 4: L register, Bs pattern.
- y_reg, input, 4: Y register, Bs blink mask.
- ram_req, output, 1: read request.
- ram_addr, output, RAM_AW: read address, valid while ram_req=1.
- ram_gnt, input, 1: read accepted this cycle.
- ram_dout, input, 4: read data, valid the clk after a granted request.
- seg, output, BANKS*SEGS: segment outputs, bank b segment s at bit b*SEGS+s.
- com, output, COMMONS: one-hot common strobe.
- bs, output, 1: backplane output.
- frame_start, output, 1: one-clk pulse when common 0 is driven.
- overrun, output, 1: sticky flag, slot tick missed; cleared only by reset.

## Operation
- Tick counter counts ce pulses 0..TICK_DIV-1. On wrap it raises an internal tick for one clk.
- FSM states:
  - IDLE: wait for tick, then go to READ with read index k=0.
  - READ:
    - ram_req=1, ram_addr=DISP_BASE+k, modulo 2^RAM_AW.
    - k advances only on a cycle with ram_gnt=1; address is held while gnt=0.
    - After the grant for k=N-1: ram_req=0, go to DRAIN.
  - DRAIN: one clk; captures the last data, then goes to LATCH.
  - LATCH: one clk, then IDLE.
- Capture: the clk after each grant for index k, shadow[k] <= ram_dout[cidx], where cidx is the current common index (0..COMMONS-1).
- LATCH actions:
  - seg <= (bp & ~bc) ? shadow : 0.
  - com <= 1<<cidx.
  - bs <= (bp & ~bc) ? ((l_reg & ~y_reg) >> cidx)[0] : 0.
  - frame_start <= (cidx==0).
  - cidx <= cidx==COMMONS-1 ? 0 : cidx+1.
- Overrun: a tick arriving while the FSM is not in IDLE sets overrun=1 and is dropped. The scan in progress completes normally. The tick counter keeps running.
- bp, bc, l_reg and y_reg are sampled only in LATCH. Changes mid-scan do not affect a partially read slot.

## Timing
- Reset values, applied asynchronously while rst=0:
  - seg=0, com=0, bs=0, frame_start=0, overrun=0, ram_req=0.
  - ram_addr=DISP_BASE, FSM=IDLE, cidx=0, tick counter=0, shadow=0.
- All outputs are registered.
- Tick at edge E0 (the edge where the counter wraps):
  - ram_req rises at E0.
  - With ram_gnt held 1, addresses DISP_BASE..+N-1 appear on consecutive cycles.
  - ram_req falls at edge E0+N.
  - seg, com and bs update at edge E0+N+2.
  - frame_start is high from E0+N+2 to E0+N+3.
- Each gnt=0 cycle during READ adds exactly one clk of latency.
- Reset deasserted mid-scan behaves as a fresh start: first slot drives common 0.
- Full frame = COMMONS*TICK_DIV ce pulses. Common 0 follows common COMMONS-1 (wrap).
- COMMONS=1: com is constantly 1 after the first LATCH, and frame_start pulses every slot.

## Test plan
- Reset release, RAM[0x60..0x7F]=4'b0101, gnt=1, bp=1, bc=0:
  - First LATCH at E0+34: seg=32'hFFFFFFFF, com=4'b0001, frame_start pulse.
  - Next slot: seg=0, com=4'b0010.
- bp=0 or bc=1 sampled at LATCH: seg=0 and bs=0, while com still rotates 0001→0010→0100→1000→0001.
- l_reg=4'b1111, y_reg=4'b0100, bp=1, bc=0:
  - Across four slots bs=1,1,0,1.
  - Second frame_start arrives 4*TICK_DIV ce pulses after the first.
- gnt toggling 1/0 each clk during READ:
  - Addresses are held on gnt=0 cycles.
  - LATCH at E0+2N+1 (±1 depending on phase) with data identical to the gnt=1 case.
- gnt=0 for more than a full slot: second tick sets overrun=1. After gnt=1 the scan completes; overrun stays 1 until rst=0, which zeroes all outputs asynchronously.
- Parameter sweep COMMONS=3, BANKS=1, SEGS=8, DISP_BASE=7'h7C: addresses wrap 7C,7D,7E,7F,00..03, and com cycles 001→010→100→001.
